// File: rtl/rv_pkg.sv
// rv_pkg: shared pipeline widths and load-type encodings
package rv_pkg;
   localparam int REG_DATA_WIDTH = 32;
   localparam int REG_ADDR_WIDTH = 5;
   typedef enum logic [2:0] {
      LD_B  = 3'b000,
      LD_H  = 3'b001,
      LD_W  = 3'b010,
      LD_BU = 3'b100,
      LD_HU = 3'b101
   } load_type_e;
endpackage

// File: rtl/wb_regfile_load_formatter.sv
// load_formatter: lane-select and sign/zero-extend a raw load word
module load_formatter
   import rv_pkg::*;
(
   input  logic [REG_DATA_WIDTH-1:0] mem_data,
   input  logic [1:0]                addr_lo,
   input  logic [2:0]                funct3,
   output logic [REG_DATA_WIDTH-1:0] data
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   // halfword lane ignores addr_lo[0]; misalignment is not trapped here
   assign byte_sel = mem_data[{addr_lo, 3'b000} +: 8];
   assign half_sel = addr_lo[1] ? mem_data[31:16] : mem_data[15:0];
   always_comb begin
      data = funct3 == LD_B  ? {{24{byte_sel[7]}}, byte_sel} :
             funct3 == LD_H  ? {{16{half_sel[15]}}, half_sel} :
             funct3 == LD_BU ? {24'h0, byte_sel} :
             funct3 == LD_HU ? {16'h0, half_sel} :
             mem_data;
   end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back select, 32-entry register file with write-through bypass, commit counter
module wb_regfile
   import rv_pkg::*;
#(
   parameter int DATA_W   = REG_DATA_WIDTH,
   parameter int ADDR_W   = REG_ADDR_WIDTH,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reg_write_wb,
   input  logic              mem_to_reg_wb,
   input  logic [DATA_W-1:0] mem_data_wb,
   input  logic [DATA_W-1:0] alu_data_wb,
   input  logic [1:0]        mem_addr_lo_wb,
   input  logic [2:0]        load_funct3_wb,
   input  logic [ADDR_W-1:0] rd_addr_wb,
   input  logic [ADDR_W-1:0] rs1_addr_id,
   input  logic [ADDR_W-1:0] rs2_addr_id,
   output logic [DATA_W-1:0] rs1_data_id,
   output logic [DATA_W-1:0] rs2_data_id,
   output logic [DATA_W-1:0] wb_data,
   output logic [31:0]       wb_commit_cnt
);
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] load_data;
   logic [31:0]       commit_cnt;
   logic              commit;

   load_formatter u_fmt (
      .mem_data (mem_data_wb),
      .addr_lo  (mem_addr_lo_wb),
      .funct3   (load_funct3_wb),
      .data     (load_data)
   );

   assign wb_data       = mem_to_reg_wb ? load_data : alu_data_wb;
   assign commit        = reg_write_wb && rd_addr_wb != '0;
   assign wb_commit_cnt = commit_cnt;

   // same-cycle bypass lets a dependent ID read see its producer without a stall
   always_comb begin
      rs1_data_id = rs1_addr_id == '0 ? '0 :
                    commit && rd_addr_wb == rs1_addr_id ? wb_data : regs[rs1_addr_id];
      rs2_data_id = rs2_addr_id == '0 ? '0 :
                    commit && rd_addr_wb == rs2_addr_id ? wb_data : regs[rs2_addr_id];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         commit_cnt <= '0;
      end else if (commit) begin
         regs[rd_addr_wb] <= wb_data;
         commit_cnt       <= commit_cnt + 32'd1;
      end
   end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and randomized checks against an array-based reference model
module tb_wb_regfile;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        reg_write_wb = 1'b0, mem_to_reg_wb = 1'b0;
   logic [31:0] mem_data_wb = '0, alu_data_wb = '0;
   logic [1:0]  mem_addr_lo_wb = '0;
   logic [2:0]  load_funct3_wb = '0;
   logic [4:0]  rd_addr_wb = '0, rs1_addr_id = '0, rs2_addr_id = '0;
   logic [31:0] rs1_data_id, rs2_data_id, wb_data, wb_commit_cnt;

   int          tests = 0;
   int          errors = 0;
   logic [31:0] mregs [32];
   logic [31:0] mcnt;

   wb_regfile dut (
      .clk(clk), .rst(rst), .reg_write_wb(reg_write_wb), .mem_to_reg_wb(mem_to_reg_wb),
      .mem_data_wb(mem_data_wb), .alu_data_wb(alu_data_wb), .mem_addr_lo_wb(mem_addr_lo_wb),
      .load_funct3_wb(load_funct3_wb), .rd_addr_wb(rd_addr_wb), .rs1_addr_id(rs1_addr_id),
      .rs2_addr_id(rs2_addr_id), .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id),
      .wb_data(wb_data), .wb_commit_cnt(wb_commit_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] mem, input int lane, input int f3);
      logic [31:0] b, h;
      b = (mem >> (8 * lane)) & 32'hFF;
      h = (mem >> (lane >= 2 ? 16 : 0)) & 32'hFFFF;
      case (f3)
         0:       return b >= 128 ? b - 32'd256 : b;
         1:       return h >= 32768 ? h - 32'd65536 : h;
         4:       return b;
         5:       return h;
         default: return mem;
      endcase
   endfunction

   function automatic logic [31:0] ref_read(input int a, input logic [31:0] wbv, input logic we, input int rd);
      if (a == 0) return 0;
      if (we && rd != 0 && rd == a) return wbv;
      return mregs[a];
   endfunction

   task automatic cyc(input logic r, input logic we, input logic m2r, input logic [31:0] mem,
                      input logic [31:0] alu, input logic [1:0] lo, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [4:0] a1, input logic [4:0] a2);
      logic [31:0] wbv;
      @(negedge clk);
      rst = r; reg_write_wb = we; mem_to_reg_wb = m2r; mem_data_wb = mem; alu_data_wb = alu;
      mem_addr_lo_wb = lo; load_funct3_wb = f3; rd_addr_wb = rd; rs1_addr_id = a1; rs2_addr_id = a2;
      #1;
      wbv = m2r ? ref_load(mem, int'(lo), int'(f3)) : alu;
      check("wb_data", wb_data, wbv);
      check("rs1", rs1_data_id, ref_read(int'(a1), wbv, we, int'(rd)));
      check("rs2", rs2_data_id, ref_read(int'(a2), wbv, we, int'(rd)));
      check("cnt", wb_commit_cnt, mcnt);
      @(posedge clk);
      if (r) begin
         foreach (mregs[i]) mregs[i] = '0;
         mcnt = '0;
      end else if (we && rd != 0) begin
         mregs[rd] = wbv;
         mcnt++;
      end
   endtask

   typedef struct { logic [2:0] f3; logic [1:0] lo; logic [31:0] exp; string tag; } ld_t;
   ld_t lds [6];

   initial begin
      foreach (mregs[i]) mregs[i] = '0;
      mcnt = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_cnt", wb_commit_cnt, 32'd0);
      for (int a = 0; a < 32; a++) begin
         rs1_addr_id = 5'(a); rs2_addr_id = 5'(31 - a);
         #1;
         check("rst_rs1", rs1_data_id, 32'd0);
         check("rst_rs2", rs2_data_id, 32'd0);
      end
      cyc(0, 1, 0, '0, 32'hDEAD_BEEF, 0, 0, 5, 0, 0);
      cyc(0, 0, 0, '0, '0, 0, 0, 0, 5, 5);
      check("x5", rs1_data_id, 32'hDEAD_BEEF);
      check("cnt1", wb_commit_cnt, 32'd1);
      cyc(0, 1, 0, '0, 32'h1234, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, '0, '0, 0, 0, 0, 0, 5);
      check("x0", rs1_data_id, 32'd0);
      check("cnt_x0", wb_commit_cnt, 32'd1);
      lds[0] = '{3'b000, 2'd3, 32'hFFFF_FF80, "lb3"};
      lds[1] = '{3'b100, 2'd3, 32'h0000_0080, "lbu3"};
      lds[2] = '{3'b001, 2'd2, 32'hFFFF_80FF, "lh2"};
      lds[3] = '{3'b101, 2'd0, 32'h0000_7F01, "lhu0"};
      lds[4] = '{3'b010, 2'd1, 32'h80FF_7F01, "lw"};
      lds[5] = '{3'b111, 2'd2, 32'h80FF_7F01, "f3_111"};
      foreach (lds[i]) begin
         @(negedge clk);
         reg_write_wb = 1'b0; mem_to_reg_wb = 1'b1; mem_data_wb = 32'h80FF_7F01;
         mem_addr_lo_wb = lds[i].lo; load_funct3_wb = lds[i].f3;
         #1;
         check(lds[i].tag, wb_data, lds[i].exp);
      end
      cyc(0, 1, 0, '0, 32'h1, 0, 0, 7, 0, 0);
      cyc(0, 1, 0, '0, 32'h2, 0, 0, 7, 7, 7);
      check("byp1", rs1_data_id, 32'h2);
      check("byp2", rs2_data_id, 32'h2);
      cyc(0, 0, 0, '0, '0, 0, 0, 0, 7, 7);
      check("x7", rs1_data_id, 32'h2);
      cyc(1, 1, 0, '0, 32'h55, 0, 0, 3, 0, 0);
      cyc(0, 0, 0, '0, '0, 0, 0, 0, 3, 7);
      check("rst_x3", rs1_data_id, 32'd0);
      check("rst_x7", rs2_data_id, 32'd0);
      check("rst_cnt0", wb_commit_cnt, 32'd0);
      cyc(0, 1, 0, '0, 32'h66, 0, 0, 3, 0, 0);
      cyc(0, 0, 0, '0, '0, 0, 0, 0, 3, 0);
      check("x3", rs1_data_id, 32'h66);
      check("cnt_after", wb_commit_cnt, 32'd1);
      @(negedge clk);
      force dut.commit_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.commit_cnt;
      mcnt = 32'hFFFF_FFFF;
      cyc(0, 1, 0, '0, 32'hA5, 0, 0, 9, 0, 0);
      cyc(0, 0, 0, '0, '0, 0, 0, 0, 9, 0);
      check("wrap", wb_commit_cnt, 32'd0);
      for (int n = 0; n < 400; n++) begin
         logic [4:0] rd;
         rd = 5'($urandom);
         cyc($urandom_range(0, 39) == 0, 1'($urandom), 1'($urandom), $urandom, $urandom,
             2'($urandom), 3'($urandom), rd,
             $urandom_range(0, 2) == 0 ? rd : 5'($urandom),
             $urandom_range(0, 2) == 0 ? rd : 5'($urandom));
      end
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
